lsu_arbiter: RTL
================

# lsu_arbiter

Two-port arbiter that shares the single load-store unit (data memory at 0x2000–0x3FFF, memory-mapped IO at 0x4000–0x7FFF) between the core pipeline (port 0) and a debug/DMA master (port 1). Requests pass through a round-robin grant stage with optional bus locking and a lock watchdog. Each granted command is registered onto the LSU port. Read data returns through a registered response stage tagged to the original requester. The block sits directly in front of the LSU; the LSU itself is unchanged.

## Interface
- LOCK_MAX, 16, maximum consecutive cycles one port may hold the lock before forced release (legal range 1–255)
- i_clk  in  1  system clock, all state on rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_req0 / i_req1  in  1  access request, held with payload until granted
- i_wren0 / i_wren1  in  1  1 = store, 0 = load
- i_addr0 / i_addr1  in  32  byte address, passed unchanged
- i_wdata0 / i_wdata1  in  32  store data
- i_lock0 / i_lock1  in  1  keep ownership after this access
- o_gnt0 / o_gnt1  out  1  combinational accept, this cycle
- o_rvalid0 / o_rvalid1  out  1  load data valid, one-cycle pulse
- o_rdata  out  32  load data, meaningful only with an rvalid
- o_lsu_addr  out  32  to LSU i_lsu_addr
- o_st_data  out  32  to LSU i_st_data
- o_lsu_wren  out  1  to LSU i_lsu_wren
- i_ld_data  in  32  from LSU o_ld_data (combinational read path)
- o_lock_owner  out  2  bit n = port n owns the lock (debug visibility)

## Operation
- Request rule: a port drives req and payload and holds them until its gnt is high. The transfer happens in the cycle where req and gnt are both high. At most one gnt is high per cycle.
- Arbitration order:
  - If no lock is owned, one requester is granted. If both request, the port not granted most recently wins. last_gnt resets to port 1, so port 0 wins the first contention.
  - If a lock is owned, only the owner can be granted. The other port is stalled even while the owner is idle.
- Lock acquisition: granting port n with i_lockn=1 sets owner=n.
- Lock release, normal: granting the owner with lock=0 clears ownership after that access.
- Lock release, forced: a watchdog counter (width clog2(LOCK_MAX+1)) clears on acquisition and increments every cycle while the lock is owned. When the counter reaches LOCK_MAX, ownership clears and last_gnt is set to the owner, so the other port wins the next contention.
- Lock release, same cycle: a normal release and watchdog expiry in the same cycle are a single release. The owner's access in that cycle is still granted.
- Command register: on grant, addr, wdata, wren and the port id are captured. The captured fields drive o_lsu_addr, o_st_data and o_lsu_wren for exactly the next cycle. If no grant occurs, o_lsu_wren is cleared; addr and data hold their last values.
- Response stage:
  - In a cycle where the command register holds a load, i_ld_data is captured into o_rdata.
  - The rvalid of the recorded port pulses in the following cycle.
  - Stores produce no rvalid.
- Throughput: back-to-back grants are legal every cycle, from either port. No downstream backpressure exists.
- Reset (i_rst low), effective immediately:
  - Registered outputs: o_lsu_wren, o_lsu_addr, o_st_data, o_rdata, o_rvalid0/1 and o_lock_owner are 0.
  - Internal state: the watchdog is 0 and last_gnt is 1.
  - o_gnt0/1 are forced 0.
- Reset mid-operation: any in-flight command or response is discarded. A store whose wren cycle is cut by reset is not performed, and no rvalid is produced after reset deasserts.

## Timing
- Cycle N: req and gnt are both high; the command is captured at the N→N+1 edge.
- Cycle N+1: the LSU sees addr/data/wren. A store commits at the N+1→N+2 edge. For a load, the LSU returns data combinationally and it is captured at the same edge.
- Cycle N+2: o_rvalidn=1 and o_rdata holds the load data. Load latency is 2 cycles from grant.
- Read-after-write to the same address on consecutive grants N, N+1: the load sees the new value, because the store commits before the load's LSU cycle.
- The lock watchdog compares after increment. An owner holding the lock from cycle A loses it at the edge ending cycle A+LOCK_MAX-1.
- gnt depends only on the current req/lock inputs and registered arbiter state. There is no combinational path from i_ld_data to any gnt.

## Test plan
- Single load: port 0 loads 0x2004 (memory holds 0xDEADBEEF) → o_gnt0 in cycle 0, o_lsu_addr=0x2004 with wren=0 in cycle 1, o_rvalid0=1 and o_rdata=0xDEADBEEF in cycle 2, o_rvalid1 stays 0.
- Contention fairness: both ports request continuously, unlocked → grants alternate 0,1,0,1…, starting with port 0 after reset.
- Lock hold and release:
  - Port 1 performs 3 locked stores then one unlocked store, while port 0 requests throughout.
  - Required: port 0 gets no grant until the cycle after port 1's fourth grant.
  - Required: o_lock_owner=2'b10 during the hold, returning to 0 after release.
- Watchdog: LOCK_MAX=4, port 1 locks once and then idles while port 0 requests → ownership clears after 4 cycles and o_gnt0 is high in the next cycle.
- IO path: port 0 stores 0x0000007F to 0x7020, then port 1 loads 0x7020 back-to-back → LSU sees wren=1 then wren=0 on consecutive cycles, and o_rvalid1 returns 0x0000007F.
- Reset mid-flight: assert i_rst low during the store's LSU cycle (N+1) → o_lsu_wren drops to 0 immediately, the target memory word is unchanged, and no rvalid follows reset deassertion.

Source files
------------

// File: rtl/lsu_arbiter.sv
// lsu_arbiter: round-robin, lockable two-port arbiter in front of the LSU.
// Ports: req/wren/addr/wdata/lock in, gnt/rvalid out per port; registered LSU cmd; o_rdata; o_lock_owner.
module lsu_arbiter #(
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic        i_wren0,
  input  logic        i_wren1,
  input  logic [31:0] i_addr0,
  input  logic [31:0] i_addr1,
  input  logic [31:0] i_wdata0,
  input  logic [31:0] i_wdata1,
  input  logic        i_lock0,
  input  logic        i_lock1,
  output logic        o_gnt0,
  output logic        o_gnt1,
  output logic        o_rvalid0,
  output logic        o_rvalid1,
  output logic [31:0] o_rdata,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_st_data,
  output logic        o_lsu_wren,
  input  logic [31:0] i_ld_data,
  output logic [1:0]  o_lock_owner
);

  localparam int WDW = $clog2(LOCK_MAX + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(LOCK_MAX);

  logic           last_gnt;
  logic [WDW-1:0] wd_q;
  logic [WDW-1:0] wd_inc;
  logic           owned;
  logic           wd_expire;
  logic           gnt_any;
  logic           sel_lock;
  logic           cmd_ld;
  logic           cmd_port;

  assign owned     = |o_lock_owner;
  assign wd_inc    = wd_q + 1'b1;
  // Compare after increment: the lock lasts LOCK_MAX owned cycles.
  assign wd_expire = owned && (wd_inc == WD_MAX);
  assign gnt_any   = o_gnt0 | o_gnt1;
  assign sel_lock  = o_gnt1 ? i_lock1 : i_lock0;

  always_comb begin
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    if (i_rst) begin
      if (owned) begin
        o_gnt0 = i_req0 & o_lock_owner[0];
        o_gnt1 = i_req1 & o_lock_owner[1];
      end else if (i_req0 & i_req1) begin
        o_gnt0 = last_gnt;
        o_gnt1 = ~last_gnt;
      end else begin
        o_gnt0 = i_req0;
        o_gnt1 = i_req1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      last_gnt     <= 1'b1;
      o_lock_owner <= 2'b00;
      wd_q         <= '0;
    end else begin
      if (o_gnt0)      last_gnt <= 1'b0;
      else if (o_gnt1) last_gnt <= 1'b1;
      if (owned) begin
        wd_q <= wd_inc;
        // Expiry and a normal release in one cycle are one release.
        if (wd_expire) begin
          o_lock_owner <= 2'b00;
          last_gnt     <= o_lock_owner[1];
          wd_q         <= '0;
        end else if (gnt_any && !sel_lock) begin
          o_lock_owner <= 2'b00;
          wd_q         <= '0;
        end
      end else if (gnt_any && sel_lock) begin
        o_lock_owner <= o_gnt1 ? 2'b10 : 2'b01;
        wd_q         <= '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_lsu_addr <= '0;
      o_st_data  <= '0;
      o_lsu_wren <= 1'b0;
      cmd_ld     <= 1'b0;
      cmd_port   <= 1'b0;
    end else if (gnt_any) begin
      o_lsu_addr <= o_gnt1 ? i_addr1  : i_addr0;
      o_st_data  <= o_gnt1 ? i_wdata1 : i_wdata0;
      o_lsu_wren <= o_gnt1 ? i_wren1  : i_wren0;
      cmd_ld     <= o_gnt1 ? ~i_wren1 : ~i_wren0;
      cmd_port   <= o_gnt1;
    end else begin
      o_lsu_wren <= 1'b0;
      cmd_ld     <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_rdata   <= '0;
      o_rvalid0 <= 1'b0;
      o_rvalid1 <= 1'b0;
    end else begin
      o_rvalid0 <= cmd_ld & ~cmd_port;
      o_rvalid1 <= cmd_ld & cmd_port;
      if (cmd_ld) o_rdata <= i_ld_data;
    end
  end

endmodule
